// File: rtl/fetch_sequencer_if.sv
// Request/response bundle between decode/branch logic and the fetch sequencer.
// The master drives run-control and jump requests; the slave returns pc, status and counters.
interface fetch_sequencer_if #(
  parameter int PW  = 10,
  parameter int OFW = 8,
  parameter int CW  = 16
);
  logic          start;
  logic          stall;
  logic          abs_jump;
  logic          rel_jump;
  logic [PW-1:0] target;
  logic [OFW-1:0] offset;
  logic          halt;
  logic [PW-1:0] pc;
  logic          running;
  logic          done;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] instr_count;

  modport master (
    output start, stall, abs_jump, rel_jump, target, offset, halt,
    input  pc, running, done, cycle_count, instr_count
  );
  modport slave (
    input  start, stall, abs_jump, rel_jump, target, offset, halt,
    output pc, running, done, cycle_count, instr_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC register plus IDLE/RUN/HALTED run control, with jumps, stall and
// saturating cycle / retired-instruction counters.
module fetch_sequencer #(
  parameter int            PW         = 10,
  parameter int            OFW        = 8,
  parameter logic [PW-1:0] START_ADDR = '0,
  parameter int            CW         = 16
) (
  input logic               clk,
  input logic               reset,
  fetch_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t state;

  logic signed [OFW-1:0] ofs;
  logic [PW-1:0]         rel_tgt;

  assign ofs     = bus.offset;
  // Sign-extending cast; the PW-bit sum wraps naturally in both directions.
  assign rel_tgt = bus.pc + PW'(ofs);

  assign bus.running = (state == RUN);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      bus.pc          <= START_ADDR;
      bus.done        <= 1'b0;
      bus.cycle_count <= '0;
      bus.instr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.pc <= START_ADDR;
          if (bus.start) state <= RUN;
        end
        RUN: begin
          bus.cycle_count <= sat_inc(bus.cycle_count);
          if (bus.halt) begin
            state           <= HALTED;
            bus.done        <= 1'b1;
            bus.instr_count <= sat_inc(bus.instr_count);
          end else if (!bus.stall) begin
            bus.instr_count <= sat_inc(bus.instr_count);
            if (bus.abs_jump)      bus.pc <= bus.target;
            else if (bus.rel_jump) bus.pc <= rel_tgt;
            else                   bus.pc <= bus.pc + PW'(1);
          end
        end
        HALTED: begin
          if (bus.start) begin
            state           <= RUN;
            bus.pc          <= START_ADDR;
            bus.done        <= 1'b0;
            bus.cycle_count <= '0;
            bus.instr_count <= '0;
          end
        end
        default: begin
          // Unreachable encoding: recover to IDLE cleanly.
          state    <= IDLE;
          bus.pc   <= START_ADDR;
          bus.done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Parametrised successor to the single-cycle core's program-counter/fetch block.
- Owns the PC register and a run-control state machine (IDLE/RUN/HALTED) with absolute and relative jumps and stall.
- Drives the core-level `done` output from a registered halt, and provides cycle and retired-instruction counters for bench measurement.
- Sits between decoder/branch logic (jump, halt, stall requests) and the instruction ROM address input.

Parameters:
- PW, 10, PC / instruction address width in bits.
- OFW, 8, relative-jump offset width; offset is two's-complement signed.
- START_ADDR, 0, PC value loaded on reset and on restart; width PW.
- CW, 16, width of cycle_count and instr_count.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level-sampled; begins execution from IDLE or restarts from HALTED.
- stall  input  1  hold PC this cycle; no instruction retires.
- abs_jump  input  1  load PC from target.
- rel_jump  input  1  add sign-extended offset to PC.
- target  input  PW  absolute jump destination.
- offset  input  OFW  signed relative jump distance.
- halt  input  1  current instruction is a halt.
- pc  output  PW  registered instruction address to the instruction ROM.
- running  output  1  high when state is RUN; decoded from the state register only.
- done  output  1  registered; high in HALTED.
- cycle_count  output  CW  RUN cycles elapsed; saturating.
- instr_count  output  CW  instructions retired; saturating.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, pc=START_ADDR, done=0, cycle_count=0, instr_count=0.
  - Reset overrides every other input in the same cycle.
  - Reset mid-RUN or in HALTED returns to IDLE; no partial update occurs.
- IDLE:
  - pc holds START_ADDR; counters hold.
  - jump, halt and stall inputs are ignored.
  - start=1 -> RUN next cycle. pc is unchanged, so the first fetch is START_ADDR.
- RUN, per-cycle priority (highest first):
  1. halt=1: next state HALTED, done=1 next cycle, pc holds, instr_count+1 (the halt instruction retires). Halt outranks stall and both jumps.
  2. stall=1: pc holds, instr_count holds.
  3. abs_jump=1: pc<=target. If rel_jump is also high, abs_jump wins.
  4. rel_jump=1: pc <= pc + sign_extend(offset) modulo 2^PW. The addition is PW bits wide, wraps in both directions, and has no overflow flag.
  5. Otherwise: pc <= pc+1, wrapping from 2^PW-1 to 0.
- Retire and count rules in RUN:
  - Cases 3-5 each retire one instruction (instr_count+1).
  - cycle_count+1 every RUN cycle, including stall and halt cycles.
- HALTED:
  - pc, counters and done hold; jump, halt and stall are ignored.
  - start=1 -> RUN next cycle with pc=START_ADDR, cycle_count=0, instr_count=0, done=0.
- Counters:
  - Each saturates at 2^CW-1 and never wraps.
  - The halt-cycle increment also saturates.
- Latency:
  - All outputs are registered except running.
  - A request sampled at edge N is visible on pc at edge N, so the ROM sees the new address in cycle N+1.
- Undefined encodings:
  - The state register has three legal values.
  - An illegal state value decodes to IDLE on the next edge.

Test Plan:
- Sequential fetch:
  - Stimulus: reset for 1 cycle, start=1 for 1 cycle, then no requests for 5 cycles.
  - Required: pc sequence 0,1,2,3,4,5; running=1; cycle_count=5; instr_count=5; done=0.
- Relative wrap, PW=10:
  - Stimulus 1: pc=2, rel_jump=1, offset=8'hFB (-5). Required: next pc=1021.
  - Stimulus 2: then offset=8'h05. Required: pc=2.
  - Stimulus 3: pc=1023 with no request. Required: pc=0.
- Priority:
  - Stimulus 1: abs_jump=1, rel_jump=1, target=300, offset=4, pc=10. Required: pc=300.
  - Stimulus 2: stall=1 together with abs_jump=1. Required: pc holds, instr_count unchanged, cycle_count+1.
  - Stimulus 3: halt=1 together with stall=1 and abs_jump=1. Required: HALTED, pc holds, done=1 next cycle, instr_count+1.
- Halt and restart:
  - Stimulus 1: run 7 instructions, then halt. Required: done=1, instr_count=8, running=0; jump and stall inputs ignored while HALTED.
  - Stimulus 2: start=1. Required: pc=START_ADDR, counters=0, done=0, running=1.
- Saturation, CW=4:
  - Stimulus: 20 RUN cycles with 3 stalls.
  - Required: cycle_count=15 and instr_count=15, both holding at 15.
- Reset mid-run:
  - Stimulus: reset=1 at pc=37 together with rel_jump=1.
  - Required: next cycle state=IDLE, pc=START_ADDR, counters=0, done=0; start is still required before any PC advance.
